operand_forward_unit: RTL and testbench

Hazard and forwarding stage between the 32×32 register file and the execute stage of the pipelined datapath. It tracks destination registers of instructions in EX, MEM and WB, and selects each decode-stage operand (A, B, D) from the register file or from an in-flight result. It raises a one-cycle stall on load-use hazards. It also drives the register file write port from its WB tracking entry.

---
 rtl/operand_forward_unit.sv | 169 ++++++++++++++++
 tb/tb_operand_forward_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_forward_unit.sv
`default_nettype none
// ============================================================================
// Module      : operand_forward_unit
// Description : Tracks EX/MEM/WB destinations, forwards decode operands from
//               in-flight results, stalls on load-use, drives regfile write.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_forward_unit (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        id_valid,
  input  logic [4:0]  id_ra,
  input  logic [4:0]  id_rb,
  input  logic [4:0]  id_rd,
  input  logic        id_use_a,
  input  logic        id_use_b,
  input  logic        id_use_d,
  input  logic        id_we,
  input  logic        id_load,
  input  logic [4:0]  id_rw,
  input  logic        flush,
  input  logic [31:0] pa,
  input  logic [31:0] pb,
  input  logic [31:0] pd,
  input  logic [31:0] ex_result,
  input  logic [31:0] mem_result,
  input  logic [31:0] wb_result,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [31:0] op_d,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [1:0]  fwd_d,
  output logic        stall,
  output logic        wb_enable,
  output logic [4:0]  wb_rw,
  output logic [15:0] stall_count
);

  localparam logic [1:0]  c_sel_rf   = 2'b00;
  localparam logic [1:0]  c_sel_ex   = 2'b01;
  localparam logic [1:0]  c_sel_mem  = 2'b10;
  localparam logic [1:0]  c_sel_wb   = 2'b11;
  localparam logic [15:0] c_cnt_max  = 16'hFFFF;

  logic        r_ex_we, r_ex_load;
  logic [4:0]  r_ex_rw;
  logic        r_mem_we, r_mem_load;
  logic [4:0]  r_mem_rw;
  logic        r_wb_we, r_wb_load;
  logic [4:0]  r_wb_rw;
  logic [15:0] r_stall_count;

  // Per-source buses, index 0 = A, 1 = B, 2 = D
  logic [14:0] w_src_bus;
  logic [2:0]  w_use_bus;
  logic [95:0] w_port_bus;
  logic [5:0]  w_fwd_bus;
  logic [2:0]  w_hz_bus;
  logic [95:0] w_op_bus;
  logic        w_stall;
  logic        w_bubble;

  assign w_src_bus  = {id_rd, id_rb, id_ra};
  assign w_use_bus  = {id_use_d, id_use_b, id_use_a};
  assign w_port_bus = {pd, pb, pa};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_src
      logic [4:0]  w_s;
      logic        w_u;
      logic [31:0] w_p;
      logic [1:0]  w_sel;
      logic        w_hz;
      logic [31:0] w_op;

      assign w_s = w_src_bus[gi*5 +: 5];
      assign w_u = w_use_bus[gi];
      assign w_p = w_port_bus[gi*32 +: 32];

      // Youngest matching stage wins; a load still in EX cannot forward yet
      always_comb begin
        w_sel = c_sel_rf;
        w_hz  = 1'b0;
        if (!w_u || (w_s == 5'd0)) begin
          w_sel = c_sel_rf;
        end else if (r_ex_we && (r_ex_rw == w_s) && r_ex_load) begin
          w_sel = c_sel_rf;
          w_hz  = 1'b1;
        end else if (r_ex_we && (r_ex_rw == w_s)) begin
          w_sel = c_sel_ex;
        end else if (r_mem_we && (r_mem_rw == w_s)) begin
          w_sel = c_sel_mem;
        end else if (r_wb_we && (r_wb_rw == w_s)) begin
          w_sel = c_sel_wb;
        end
      end

      always_comb begin
        w_op = w_p;
        case (w_sel)
          c_sel_ex:  w_op = ex_result;
          c_sel_mem: w_op = mem_result;
          c_sel_wb:  w_op = wb_result;
          default:   w_op = w_p;
        endcase
      end

      assign w_fwd_bus[gi*2 +: 2]  = w_sel;
      assign w_hz_bus[gi]          = w_hz;
      assign w_op_bus[gi*32 +: 32] = w_op;
    end
  endgenerate

  assign w_stall  = id_valid & ~flush & (|w_hz_bus);
  assign w_bubble = w_stall | flush;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_ex_we       <= 1'b0;
      r_ex_load     <= 1'b0;
      r_ex_rw       <= 5'd0;
      r_mem_we      <= 1'b0;
      r_mem_load    <= 1'b0;
      r_mem_rw      <= 5'd0;
      r_wb_we       <= 1'b0;
      r_wb_load     <= 1'b0;
      r_wb_rw       <= 5'd0;
      r_stall_count <= 16'd0;
    end else begin
      r_wb_we    <= r_mem_we;
      r_wb_load  <= r_mem_load;
      r_wb_rw    <= r_mem_rw;
      r_mem_we   <= r_ex_we;
      r_mem_load <= r_ex_load;
      r_mem_rw   <= r_ex_rw;
      if (w_bubble) begin
        r_ex_we   <= 1'b0;
        r_ex_load <= 1'b0;
        r_ex_rw   <= 5'd0;
      end else begin
        r_ex_we   <= id_we & id_valid;
        r_ex_load <= id_load;
        r_ex_rw   <= id_rw;
      end
      if (w_stall && (r_stall_count != c_cnt_max)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
    end
  end

  assign op_a        = w_op_bus[31:0];
  assign op_b        = w_op_bus[63:32];
  assign op_d        = w_op_bus[95:64];
  assign fwd_a       = w_fwd_bus[1:0];
  assign fwd_b       = w_fwd_bus[3:2];
  assign fwd_d       = w_fwd_bus[5:4];
  assign stall       = w_stall;
  assign wb_enable   = r_wb_we;
  assign wb_rw       = r_wb_rw;
  assign stall_count = r_stall_count;

  // Load flags travel with the entries but only EX's is consulted
  logic w_unused;
  assign w_unused = r_wb_load;

endmodule
`default_nettype wire

// File: tb/tb_operand_forward_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_forward_unit
// Description : Directed plus randomized bench with a stage-list reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_forward_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        id_valid, id_use_a, id_use_b, id_use_d, id_we, id_load, flush;
  logic [4:0]  id_ra, id_rb, id_rd, id_rw;
  logic [31:0] pa, pb, pd, ex_result, mem_result, wb_result;
  logic [31:0] op_a, op_b, op_d;
  logic [1:0]  fwd_a, fwd_b, fwd_d;
  logic        stall, wb_enable;
  logic [4:0]  wb_rw;
  logic [15:0] stall_count;

  int n_vec = 0;
  int n_err = 0;

  operand_forward_unit dut (
    .clock(clock), .reset_n(reset_n), .id_valid(id_valid),
    .id_ra(id_ra), .id_rb(id_rb), .id_rd(id_rd),
    .id_use_a(id_use_a), .id_use_b(id_use_b), .id_use_d(id_use_d),
    .id_we(id_we), .id_load(id_load), .id_rw(id_rw), .flush(flush),
    .pa(pa), .pb(pb), .pd(pd),
    .ex_result(ex_result), .mem_result(mem_result), .wb_result(wb_result),
    .op_a(op_a), .op_b(op_b), .op_d(op_d),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_d(fwd_d),
    .stall(stall), .wb_enable(wb_enable), .wb_rw(wb_rw),
    .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  // Reference model: in-flight instruction list, index 0 = youngest (EX)
  logic       m_we   [3];
  logic       m_load [3];
  logic [4:0] m_rw   [3];
  int         m_cnt;
  bit         m_init = 0;

  // Returns {hazard, select[1:0]}
  function automatic logic [2:0] msel(input logic u, input logic [4:0] s);
    if (!u || s == 5'd0) return 3'b000;
    for (int k = 0; k < 3; k++) begin
      if (m_we[k] && m_rw[k] == s) begin
        if (k == 0 && m_load[0]) return 3'b100;
        return {1'b0, 2'(k + 1)};
      end
    end
    return 3'b000;
  endfunction

  function automatic logic [31:0] mop(input logic [1:0] sel, input logic [31:0] p);
    case (sel)
      2'd1:    return ex_result;
      2'd2:    return mem_result;
      2'd3:    return wb_result;
      default: return p;
    endcase
  endfunction

  function automatic logic mstall();
    logic [2:0] a, b, d;
    a = msel(id_use_a, id_ra);
    b = msel(id_use_b, id_rb);
    d = msel(id_use_d, id_rd);
    return id_valid && !flush && (a[2] || b[2] || d[2]);
  endfunction

  always @(posedge clock) begin
    if (!reset_n) begin
      for (int k = 0; k < 3; k++) begin
        m_we[k] = 1'b0; m_load[k] = 1'b0; m_rw[k] = 5'd0;
      end
      m_cnt  = 0;
      m_init = 1;
    end else if (m_init) begin
      logic st;
      st = mstall();
      if (st && m_cnt < 65535) m_cnt = m_cnt + 1;
      for (int k = 2; k > 0; k--) begin
        m_we[k] = m_we[k-1]; m_load[k] = m_load[k-1]; m_rw[k] = m_rw[k-1];
      end
      if (st || flush) begin
        m_we[0] = 1'b0; m_load[0] = 1'b0; m_rw[0] = 5'd0;
      end else begin
        m_we[0] = id_we && id_valid; m_load[0] = id_load; m_rw[0] = id_rw;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (m_init) begin
      logic [2:0] a, b, d;
      a = msel(id_use_a, id_ra);
      b = msel(id_use_b, id_rb);
      d = msel(id_use_d, id_rd);
      chk("model fwd_a", 32'(fwd_a), 32'(a[1:0]));
      chk("model fwd_b", 32'(fwd_b), 32'(b[1:0]));
      chk("model fwd_d", 32'(fwd_d), 32'(d[1:0]));
      chk("model op_a", op_a, mop(a[1:0], pa));
      chk("model op_b", op_b, mop(b[1:0], pb));
      chk("model op_d", op_d, mop(d[1:0], pd));
      chk("model stall", 32'(stall), 32'(mstall()));
      chk("model wb_enable", 32'(wb_enable), 32'(m_we[2]));
      if (m_we[2]) chk("model wb_rw", 32'(wb_rw), 32'(m_rw[2]));
      chk("model stall_count", 32'(stall_count), 32'(m_cnt));
    end
  end

  task automatic idle();
    id_valid = 0; id_use_a = 0; id_use_b = 0; id_use_d = 0;
    id_we = 0; id_load = 0; flush = 0;
    id_ra = 0; id_rb = 0; id_rd = 0; id_rw = 0;
    pa = 0; pb = 0; pd = 0;
    ex_result = 32'h1111_1111; mem_result = 32'h2222_2222; wb_result = 32'h3333_3333;
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic at_check();
    @(negedge clock);
    #1;
  endtask

  task automatic issue(input logic ld, input logic [4:0] rw);
    idle();
    id_valid = 1; id_we = 1; id_load = ld; id_rw = rw;
  endtask

  initial begin
    idle();
    reset_n = 0;
    step(2);
    reset_n = 1;
    at_check();
    chk("reset wb_enable", 32'(wb_enable), 32'd0);
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset fwd", {26'd0, fwd_d, fwd_b, fwd_a}, 32'd0);
    chk("reset stall_count", 32'(stall_count), 32'd0);

    // EX forward
    issue(0, 5'd3);
    step();
    idle(); id_valid = 1; id_ra = 3; id_use_a = 1; ex_result = 32'h0000_1234;
    at_check();
    chk("exfwd fwd_a", 32'(fwd_a), 32'd1);
    chk("exfwd op_a", op_a, 32'h0000_1234);
    chk("exfwd stall", 32'(stall), 32'd0);

    // EX beats MEM
    step(); issue(0, 5'd5);
    step(); issue(0, 5'd5);
    step(); idle(); id_valid = 1; id_rb = 5; id_use_b = 1;
    at_check();
    chk("prio fwd_b ex", 32'(fwd_b), 32'd1);
    step();
    at_check();
    chk("prio fwd_b mem", 32'(fwd_b), 32'd2);

    // Load-use
    step(); idle(); step(3);
    issue(1, 5'd7);
    step();
    idle(); id_valid = 1; id_rd = 7; id_use_d = 1; mem_result = 32'hCAFE_0007;
    at_check();
    chk("loaduse stall", 32'(stall), 32'd1);
    step();
    at_check();
    chk("loaduse stall released", 32'(stall), 32'd0);
    chk("loaduse stall_count", 32'(stall_count), 32'd1);
    chk("loaduse fwd_d", 32'(fwd_d), 32'd2);
    chk("loaduse op_d", op_d, 32'hCAFE_0007);
    step(); idle();
    at_check();
    chk("loaduse wb_enable", 32'(wb_enable), 32'd1);
    chk("loaduse wb_rw", 32'(wb_rw), 32'd7);

    // r0 never forwards
    step(3);
    issue(0, 5'd0);
    step();
    idle(); id_valid = 1; id_ra = 0; id_use_a = 1; pa = 0; ex_result = 32'hDEAD_BEEF;
    at_check();
    chk("r0 fwd_a", 32'(fwd_a), 32'd0);
    chk("r0 op_a", op_a, 32'd0);

    // Flush wins over load-use
    step(); idle(); step(3);
    issue(1, 5'd9);
    step();
    idle(); id_valid = 1; id_we = 1; id_rw = 10; id_rd = 9; id_use_d = 1; flush = 1;
    at_check();
    chk("flush stall", 32'(stall), 32'd0);
    chk("flush stall_count", 32'(stall_count), 32'd1);
    step(); idle();
    step();
    at_check();
    chk("flush load wb_enable", 32'(wb_enable), 32'd1);
    chk("flush load wb_rw", 32'(wb_rw), 32'd9);
    chk("flush stall_count kept", 32'(stall_count), 32'd1);
    step();
    at_check();
    chk("flush bubble wb_enable", 32'(wb_enable), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step();
      reset_n    = ($urandom_range(0, 255) != 0);
      id_valid   = ($urandom_range(0, 7) != 0);
      id_ra      = 5'($urandom_range(0, 7));
      id_rb      = 5'($urandom_range(0, 7));
      id_rd      = 5'($urandom_range(0, 7));
      id_rw      = 5'($urandom_range(0, 7));
      id_use_a   = 1'($urandom_range(0, 1));
      id_use_b   = 1'($urandom_range(0, 1));
      id_use_d   = 1'($urandom_range(0, 1));
      id_we      = ($urandom_range(0, 3) != 0);
      id_load    = ($urandom_range(0, 3) == 0);
      flush      = ($urandom_range(0, 15) == 0);
      pa         = $urandom(); pb = $urandom(); pd = $urandom();
      ex_result  = $urandom(); mem_result = $urandom(); wb_result = $urandom();
    end
    step();
    idle();
    reset_n = 1;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
